mem_stage_v2: RTL
=================

# mem_stage_v2

Parametrised memory stage for the five-stage pipeline, sitting between EX and WB. It replaces the fixed 128-byte, combinational-read data memory with a synchronous byte-addressed RAM of configurable depth. It adds RISC-V load sign/zero extension, store byte-lane selection, misalignment detection and a valid/ready handshake that stalls upstream during the load read cycle. It also generalises the video-memory scan-out to a configurable window size and base.

## Interface
Parameters:
- XLEN, 64, datapath width (32 or 64).
- DEPTH, 1024, data RAM size in bytes (power of two, ≥ 16).
- VMEM_BYTES, 8, bytes in the scan-out window (power of two, ≥ 1).
- VMEM_BASE, DEPTH-8, byte address of window start (VMEM_BASE+VMEM_BYTES ≤ DEPTH).
- INIT_FILE, "", hex image loaded into RAM at elaboration if non-empty.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream op present.
- ready_out  out  1  stage can accept; op accepted when valid_in && ready_out.
- wb_select  in  2  00 alu_res, 01 load data, 10 pc_plus_4, 11 alu_res.
- mem_read  in  1  op is a load (must accompany wb_select=01).
- mem_write  in  1  op is a store.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- pc_plus_4  in  XLEN  return address.
- alu_res  in  XLEN  effective address / ALU result.
- rs2_data  in  XLEN  store data.
- valid_out  out  1  write_back_data/err valid this cycle (single-cycle pulse per op).
- write_back_data  out  XLEN  result to WB.
- err  out  1  access was misaligned or illegal; qualified by valid_out.
- vmem_data  out  8*VMEM_BYTES  scan-out shadow; byte i = bits [8i+7:8i].

## Operation
- Address = alu_res[log2(DEPTH)-1:0]; upper bits ignored (wrap modulo DEPTH). Little-endian byte order.
- Access size N = 1/2/4/8 bytes from funct3[1:0]. With XLEN=32, D/WU are illegal.
- Error: mem_read or mem_write, and (address mod N ≠ 0 or funct3 illegal). An error op performs no write and does not enter LOAD. It returns valid_out=1, err=1, write_back_data=0.
- Store: writes N bytes of rs2_data[8N-1:0] at the acceptance edge. Result is wb_select mux (normally alu_res).
- Load: sign-extends from bit 8N-1 (B/H/W), or zero-extends (BU/HU/WU). D is taken as-is.
- mem_read && mem_write together: the load wins and the store is ignored.
- FSM:
  - IDLE: ready_out=1.
    - Accepted load without error → LOAD; registered RAM read of 8 bytes at address.
    - Other accepted op → result registered; valid_out=1 next cycle; stay IDLE.
    - No op → valid_out=0 next cycle.
  - LOAD: ready_out=0. Extend the registered read data, drive valid_out=1 next cycle, → IDLE.
- Scan-out: counter cnt (log2 VMEM_BYTES bits, 0 if VMEM_BYTES=1) increments every cycle with wrap. Each cycle shadow[cnt] ← RAM[VMEM_BASE+cnt] via an independent read port. The full window refreshes every VMEM_BYTES cycles.
- Read-during-write on the same byte: both the load port and the scan port return the old data.

## Timing
- Reset: state=IDLE, valid_out=0, err=0, write_back_data=0, cnt=0, vmem_data=0. ready_out=1 from the first cycle after reset. RAM contents are not cleared.
- Latency from acceptance edge to valid_out: 1 cycle for non-load or error ops; 2 cycles for good loads.
- Throughput: one non-load op per cycle. A load blocks acceptance for exactly one cycle.
- Reset asserted in LOAD: abort, no valid_out, → IDLE.
- Reset coincident with a store: the store is suppressed.
- valid_in while ready_out=0: ignored; upstream holds.
- Load immediately following a store to the same address (back-to-back acceptance): returns the stored data.

## Test plan
- Reset, then store SD 0x1122334455667788 @0x40; LD @0x40 → valid_out 2 cycles after acceptance, data 0x1122334455667788, ready_out low exactly 1 cycle.
- SB 0x80 @0x10, then LB @0x10 → 0xFFFFFFFFFFFFFF80; LBU @0x10 → 0x0000000000000080.
- LW @0x42 and SH @0x41 → err=1, write_back_data=0, latency 1; RAM bytes 0x40-0x47 unchanged.
- Back-to-back ALU ops (wb_select 00, then 10 with pc_plus_4=0x104) → valid_out on consecutive cycles with alu_res, then 0x104; ready_out stays 1.
- SD 0x0807060504030201 @VMEM_BASE; after VMEM_BYTES+2 cycles → vmem_data=0x0807060504030201. Address VMEM_BASE+DEPTH aliases to VMEM_BASE.
- Accept load, assert sys_rst the next cycle → no valid_out, ready_out=1 after reset, outputs 0.

Source files
------------

// File: rtl/mem_stage_v2.sv
// mem_stage_v2 -- memory stage between EX and WB.
//
// Synchronous byte-addressed data RAM with RISC-V load extension, store
// byte-lane selection, misalignment/illegal-size detection and a one-cycle
// upstream stall while a load reads the RAM. A second read port continuously
// refreshes a shadow copy of a small RAM window for video scan-out.
//
// Ports:
//   sys_clk          clock, all state updates on the rising edge
//   sys_rst          synchronous active-high reset
//   valid_in         upstream op present
//   ready_out        stage can accept (op accepted when valid_in && ready_out)
//   wb_select        00 alu_res, 01 load data, 10 pc_plus_4, 11 alu_res
//   mem_read         op is a load
//   mem_write        op is a store
//   funct3           access size/sign: B H W D BU HU WU, 111 illegal
//   pc_plus_4        return address
//   alu_res          effective address / ALU result
//   rs2_data         store data
//   valid_out        single-cycle pulse per completed op
//   write_back_data  result to WB
//   err              misaligned or illegal access, qualified by valid_out
//   vmem_data        scan-out shadow, byte i at bits [8i+7:8i]

module mem_stage_v2 #(
  parameter int    XLEN       = 64,
  parameter int    DEPTH      = 1024,
  parameter int    VMEM_BYTES = 8,
  parameter int    VMEM_BASE  = DEPTH - 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [1:0]              wb_select,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [2:0]              funct3,
  input  logic [XLEN-1:0]         pc_plus_4,
  input  logic [XLEN-1:0]         alu_res,
  input  logic [XLEN-1:0]         rs2_data,
  output logic                    valid_out,
  output logic [XLEN-1:0]         write_back_data,
  output logic                    err,
  output logic [8*VMEM_BYTES-1:0] vmem_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (VMEM_BYTES > 1) ? $clog2(VMEM_BYTES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [7:0] mem [DEPTH];

  // Sign- or zero-extend the low bytes of a raw 8-byte little-endian read.
  function automatic logic [63:0] load_ext(input logic [63:0] raw,
                                           input logic [2:0]  f3);
    logic [63:0] r;
    case (f3)
      3'b000:  r = {{56{raw[7]}},  raw[7:0]};
      3'b001:  r = {{48{raw[15]}}, raw[15:0]};
      3'b010:  r = {{32{raw[31]}}, raw[31:0]};
      3'b100:  r = {56'd0, raw[7:0]};
      3'b101:  r = {48'd0, raw[15:0]};
      3'b110:  r = {32'd0, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- stage p0
  // Decode of the op presented by EX, evaluated in the acceptance cycle.
  logic [AW-1:0]  addr_p0;
  logic [3:0]     nbytes_p0;
  logic [2:0]     align_mask_p0;
  logic           illegal_p0;
  logic           misal_p0;
  logic           bad_p0;
  logic           accept_p0;
  logic           good_load_p0;
  logic           do_store_p0;
  logic [63:0]    st_data_p0;
  logic [XLEN-1:0] wb_res_p0;

  assign addr_p0    = alu_res[AW-1:0];
  assign st_data_p0 = 64'(rs2_data);

  always_comb begin
    nbytes_p0     = 4'd1;
    align_mask_p0 = 3'b000;
    case (funct3[1:0])
      2'b00: begin nbytes_p0 = 4'd1; align_mask_p0 = 3'b000; end
      2'b01: begin nbytes_p0 = 4'd2; align_mask_p0 = 3'b001; end
      2'b10: begin nbytes_p0 = 4'd4; align_mask_p0 = 3'b011; end
      default: begin nbytes_p0 = 4'd8; align_mask_p0 = 3'b111; end
    endcase
  end

  // On a 32-bit datapath there are no doubleword or unsigned-word accesses.
  always_comb begin
    illegal_p0 = (funct3 == 3'b111);
    if (XLEN == 32) begin
      if (funct3[1:0] == 2'b11 || funct3 == 3'b110) begin
        illegal_p0 = 1'b1;
      end
    end
  end

  assign misal_p0     = |(addr_p0[2:0] & align_mask_p0);
  assign bad_p0       = (mem_read | mem_write) & (illegal_p0 | misal_p0);
  assign accept_p0    = valid_in & ready_out;
  assign good_load_p0 = accept_p0 & mem_read & ~bad_p0;
  // A simultaneous load wins over the store; reset on the same edge kills it.
  assign do_store_p0  = accept_p0 & mem_write & ~mem_read & ~bad_p0 & ~sys_rst;

  always_comb begin
    wb_res_p0 = alu_res;
    if (wb_select == 2'b10) begin
      wb_res_p0 = pc_plus_4;
    end
  end

  // FSM: IDLE accepts ops; LOAD is the single stall cycle of a load.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in && mem_read && !bad_p0) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RAM write port. Bytes beyond the access size keep their contents; the
  // address wraps modulo DEPTH.
  always_ff @(posedge sys_clk) begin
    if (do_store_p0) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nbytes_p0)) begin
          mem[addr_p0 + AW'(k)] <= st_data_p0[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage p1
  // Registered 8-byte load read; non-blocking reads return pre-write data.
  logic [63:0] rd_p1;
  logic [2:0]  f3_p1;
  logic [63:0] ld_ext_p1;

  always_ff @(posedge sys_clk) begin
    if (good_load_p0) begin
      for (int k = 0; k < 8; k++) begin
        rd_p1[8*k +: 8] <= mem[addr_p0 + AW'(k)];
      end
      f3_p1 <= funct3;
    end
  end

  assign ld_ext_p1 = load_ext(rd_p1, f3_p1);

  // Result register: a load completes from LOAD, everything else (including
  // faulting memory ops) completes one cycle after acceptance.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      valid_out       <= 1'b0;
      err             <= 1'b0;
      write_back_data <= '0;
    end else begin
      valid_out <= 1'b0;
      if (state == LOAD) begin
        valid_out       <= 1'b1;
        err             <= 1'b0;
        write_back_data <= ld_ext_p1[XLEN-1:0];
      end else if (accept_p0 && !good_load_p0) begin
        valid_out       <= 1'b1;
        err             <= bad_p0;
        write_back_data <= bad_p0 ? '0 : wb_res_p0;
      end
    end
  end

  // Scan-out: one window byte refreshed per cycle through its own read port.
  logic [CW-1:0] cnt;
  logic [AW-1:0] scan_addr;

  assign scan_addr = AW'(VMEM_BASE) + AW'(cnt);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt       <= '0;
      vmem_data <= '0;
    end else begin
      cnt <= (VMEM_BYTES > 1) ? cnt + CW'(1) : '0;
      vmem_data[8*int'(cnt) +: 8] <= mem[scan_addr];
    end
  end

endmodule
